// File: rtl/rename_unit_ckpt.sv
// Register-rename stage with a speculative RAT, a retirement RAT and checkpointed free lists.
// A flush restores the mapping, free list and tag pointer from committed state in one cycle.
module rename_unit_ckpt #(
  parameter  int ARCH_REGS = 32,
  parameter  int PHYS_REGS = 128,
  parameter  int ROB_DEPTH = 16,
  parameter  int PC_W      = 9,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int TW        = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [PW-1:0]   out_prs1,
  output logic [PW-1:0]   out_prs2,
  output logic [PW-1:0]   out_prd,
  output logic [PW-1:0]   out_old_prd,
  output logic [TW-1:0]   out_rob_tag,
  input  logic            commit_valid,
  input  logic            commit_rd_we,
  input  logic [AW-1:0]   commit_rd,
  input  logic [PW-1:0]   commit_prd,
  input  logic [PW-1:0]   commit_old_prd,
  input  logic            flush
);

  localparam logic [PHYS_REGS-1:0] FREE_INIT = {PHYS_REGS{1'b1}} << ARCH_REGS;
  localparam logic [TW:0]          INFLIGHT_MAX = (TW+1)'(ROB_DEPTH);

  logic [PW-1:0]        rat_q [ARCH_REGS];
  logic [PW-1:0]        rat_d [ARCH_REGS];
  logic [PW-1:0]        rrat_q [ARCH_REGS];
  logic [PW-1:0]        rrat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] spec_free_q, spec_free_d;
  logic [PHYS_REGS-1:0] arch_free_q, arch_free_d;
  logic [TW-1:0]        tag_ptr_q, tag_ptr_d;
  logic [TW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [TW:0]          inflight_q, inflight_d;
  logic                 out_valid_q, out_valid_d;
  logic [PC_W-1:0]      out_pc_q, out_pc_d;
  logic [PW-1:0]        out_prs1_q, out_prs1_d;
  logic [PW-1:0]        out_prs2_q, out_prs2_d;
  logic [PW-1:0]        out_prd_q, out_prd_d;
  logic [PW-1:0]        out_old_prd_q, out_old_prd_d;
  logic [TW-1:0]        out_rob_tag_q, out_rob_tag_d;

  logic          needs_alloc, accept, commit_upd;
  logic [PW-1:0] alloc_prd;

  always_comb begin
    needs_alloc = in_rd_we && (in_rd != '0);
    // Descending scan so the lowest free register is the last one written.
    alloc_prd = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (spec_free_q[i]) alloc_prd = PW'(i);
    end
    in_ready = !flush && (!out_valid_q || out_ready) && (inflight_q < INFLIGHT_MAX) &&
               (!needs_alloc || (|spec_free_q));
    accept     = in_valid && in_ready;
    commit_upd = commit_valid && commit_rd_we && (commit_rd != '0);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    rat_d         = rat_q;
    rrat_d        = rrat_q;
    spec_free_d   = spec_free_q;
    arch_free_d   = arch_free_q;
    tag_ptr_d     = tag_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    inflight_d    = inflight_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_prs1_d    = out_prs1_q;
    out_prs2_d    = out_prs2_q;
    out_prd_d     = out_prd_q;
    out_old_prd_d = out_old_prd_q;
    out_rob_tag_d = out_rob_tag_q;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_prs1_d    = rat_q[in_rs1];
      out_prs2_d    = rat_q[in_rs2];
      out_rob_tag_d = tag_ptr_q;
      tag_ptr_d     = tag_ptr_q + TW'(1);
      if (needs_alloc) begin
        out_prd_d              = alloc_prd;
        out_old_prd_d          = rat_q[in_rd];
        rat_d[in_rd]           = alloc_prd;
        spec_free_d[alloc_prd] = 1'b0;
      end else begin
        out_prd_d     = '0;
        out_old_prd_d = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (commit_valid) begin
      commit_ptr_d = commit_ptr_q + TW'(1);
      if (commit_upd) begin
        rrat_d[commit_rd]           = commit_prd;
        arch_free_d[commit_prd]     = 1'b0;
        arch_free_d[commit_old_prd] = 1'b1;
        spec_free_d[commit_old_prd] = 1'b1;
      end
    end

    case ({accept, commit_valid})
      2'b10:   inflight_d = inflight_q + (TW+1)'(1);
      2'b01:   inflight_d = inflight_q - (TW+1)'(1);
      default: inflight_d = inflight_q;
    endcase

    // Recovery builds on the post-commit architectural state of this same cycle.
    if (flush) begin
      rat_d       = rrat_d;
      spec_free_d = arch_free_d;
      tag_ptr_d   = commit_ptr_d;
      inflight_d  = '0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: both RATs must come out of reset as the identity map, so these arrays are
  // deliberately reset rather than left as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        rrat_q[i] <= PW'(i);
      end
      spec_free_q   <= FREE_INIT;
      arch_free_q   <= FREE_INIT;
      tag_ptr_q     <= '0;
      commit_ptr_q  <= '0;
      inflight_q    <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_prs1_q    <= '0;
      out_prs2_q    <= '0;
      out_prd_q     <= '0;
      out_old_prd_q <= '0;
      out_rob_tag_q <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge value of its neighbours.
      rat_q         <= rat_d;
      rrat_q        <= rrat_d;
      spec_free_q   <= spec_free_d;
      arch_free_q   <= arch_free_d;
      tag_ptr_q     <= tag_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      inflight_q    <= inflight_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_prs1_q    <= out_prs1_d;
      out_prs2_q    <= out_prs2_d;
      out_prd_q     <= out_prd_d;
      out_old_prd_q <= out_old_prd_d;
      out_rob_tag_q <= out_rob_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_prs1    = out_prs1_q;
  assign out_prs2    = out_prs2_q;
  assign out_prd     = out_prd_q;
  assign out_old_prd = out_old_prd_q;
  assign out_rob_tag = out_rob_tag_q;

  a_commit_needs_inflight: assert property (
    @(posedge clk) disable iff (rst) commit_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_rename_unit_ckpt.sv
// Directed bench for rename_unit_ckpt built with a 40-entry physical file so the
// free-list exhaustion case is reachable with a handful of renames.
module tb_rename_unit_ckpt;

  localparam int PC_W = 9;
  localparam int AW   = 5;
  localparam int PW   = 6;
  localparam int TW   = 4;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            we;
    logic [PW-1:0]   prs1, prs2, prd, old;
    logic [TW-1:0]   tag;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0, in_rd_we = 1'b0, out_ready = 1'b1;
  logic [PC_W-1:0] in_pc = '0;
  logic [AW-1:0]   in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic            commit_valid = 1'b0, commit_rd_we = 1'b0, flush = 1'b0;
  logic [AW-1:0]   commit_rd = '0;
  logic [PW-1:0]   commit_prd = '0, commit_old_prd = '0;
  logic            in_ready, out_valid;
  logic [PC_W-1:0] out_pc;
  logic [PW-1:0]   out_prs1, out_prs2, out_prd, out_old_prd;
  logic [TW-1:0]   out_rob_tag;

  int n_cmp = 0;
  int n_err = 0;

  rename_unit_ckpt #(.ARCH_REGS(32), .PHYS_REGS(40), .ROB_DEPTH(16), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_rob_tag(out_rob_tag),
    .commit_valid(commit_valid), .commit_rd_we(commit_rd_we), .commit_rd(commit_rd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd), .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int pc, input int rs1, input int rs2, input int rd,
                              input bit we, input int prs1, input int prs2, input int prd,
                              input int old, input int tag);
    vec_t v;
    v.pc = PC_W'(pc); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd); v.we = we;
    v.prs1 = PW'(prs1); v.prs2 = PW'(prs2); v.prd = PW'(prd); v.old = PW'(old);
    v.tag = TW'(tag);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_rd = v.rd; in_rd_we = v.we;
  endtask

  task automatic check_out(input string name, input vec_t v);
    check({name, ".valid"}, 32'(out_valid), 1);
    check({name, ".pc"},    32'(out_pc), 32'(v.pc));
    check({name, ".prs1"},  32'(out_prs1), 32'(v.prs1));
    check({name, ".prs2"},  32'(out_prs2), 32'(v.prs2));
    check({name, ".prd"},   32'(out_prd), 32'(v.prd));
    check({name, ".old"},   32'(out_old_prd), 32'(v.old));
    check({name, ".tag"},   32'(out_rob_tag), 32'(v.tag));
  endtask

  // Presents one instruction, expects it accepted at the next edge, checks the result.
  task automatic apply(input string name, input vec_t v);
    drive(v);
    #1;
    check({name, ".in_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    check_out(name, v);
    in_valid = 1'b0; in_rd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  vec_t t1 [5];
  vec_t v;

  initial begin
    // ADDI x1,x0 / ADD x2,x1,x0 / ADD x3,x1,x2 / LUI x4 / BEQ x1,x2
    t1[0] = mk(1, 0, 0, 1, 1,  0,  0, 32, 1, 0);
    t1[1] = mk(2, 1, 0, 2, 1, 32,  0, 33, 2, 1);
    t1[2] = mk(3, 1, 2, 3, 1, 32, 33, 34, 3, 2);
    t1[3] = mk(4, 0, 0, 4, 1,  0,  0, 35, 4, 3);
    t1[4] = mk(5, 1, 2, 0, 0, 32, 33,  0, 0, 4);

    #12 rst = 1'b0;
    in_rd = 5'd1; in_rd_we = 1'b1;
    #1;
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_pc", 32'(out_pc), 0);
    check("reset.out_prd", 32'(out_prd), 0);
    check("reset.out_rob_tag", 32'(out_rob_tag), 0);
    check("reset.in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 5; i++) apply($sformatf("stream%0d", i), t1[i]);

    // Downstream backpressure for three cycles.
    apply("bp_a", mk(6, 1, 2, 5, 1, 32, 33, 36, 5, 5));
    out_ready = 1'b0;
    drive(mk(7, 5, 0, 6, 1, 36, 0, 37, 6, 6));
    #1;
    check("bp.in_ready0", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 1);
      check($sformatf("bp.hold%0d.prd", i), 32'(out_prd), 36);
      check($sformatf("bp.hold%0d.tag", i), 32'(out_rob_tag), 5);
      check($sformatf("bp.hold%0d.in_ready", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    apply("bp_b", mk(7, 5, 0, 6, 1, 36, 0, 37, 6, 6));

    // Exhaust the 8 non-architectural registers.
    apply("fill_x7", mk(8, 0, 0, 7, 1, 0, 0, 38, 7, 7));
    apply("fill_x8", mk(9, 0, 0, 8, 1, 0, 0, 39, 8, 8));
    drive(mk(10, 1, 0, 9, 1, 0, 0, 0, 0, 0));
    #1;
    check("full.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("full.no_accept", 32'(out_valid), 0);
    check("full.still_stalled", 32'(in_ready), 0);
    apply("full_beq", mk(11, 7, 8, 0, 0, 38, 39, 0, 0, 9));

    // Commit ADDI x1: P1 becomes free, but only from the following cycle.
    commit_valid = 1'b1; commit_rd_we = 1'b1; commit_rd = 5'd1;
    commit_prd = 6'd32; commit_old_prd = 6'd1;
    drive(mk(12, 1, 0, 9, 1, 0, 0, 0, 0, 0));
    #1;
    check("commit.no_bypass", 32'(in_ready), 0);
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_rd_we = 1'b0;
    apply("after_commit", mk(12, 1, 0, 9, 1, 32, 0, 1, 9, 10));

    // Flush with a same-cycle commit of the oldest instruction.
    do_reset();
    apply("fl_x1", mk(16, 0, 0, 1, 1, 0, 0, 32, 1, 0));
    apply("fl_x2", mk(17, 1, 0, 2, 1, 32, 0, 33, 2, 1));
    commit_valid = 1'b1; commit_rd_we = 1'b1; commit_rd = 5'd1;
    commit_prd = 6'd32; commit_old_prd = 6'd1;
    flush = 1'b1;
    drive(mk(18, 1, 2, 5, 1, 0, 0, 0, 0, 0));
    #1;
    check("flush.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_rd_we = 1'b0; flush = 1'b0;
    check("flush.out_valid", 32'(out_valid), 0);
    // x2 rolls back to P2; P1 was returned by the commit and is now the lowest free.
    apply("post_flush", mk(18, 1, 2, 5, 1, 32, 2, 1, 5, 1));
    apply("post_flush2", mk(19, 0, 0, 6, 1, 0, 0, 33, 6, 2));

    // ROB occupancy limit and tag wrap.
    do_reset();
    for (int i = 0; i < 16; i++) apply($sformatf("rob%0d", i), mk(32 + i, 1, 2, 0, 0, 1, 2, 0, 0, i));
    drive(mk(48, 3, 4, 0, 0, 3, 4, 0, 0, 0));
    #1;
    check("rob_full.in_ready", 32'(in_ready), 0);
    commit_valid = 1'b1;
    #1;
    check("rob_full.commit_cycle", 32'(in_ready), 0);
    @(posedge clk); #1;
    commit_valid = 1'b0;
    apply("rob_wrap", mk(48, 3, 4, 0, 0, 3, 4, 0, 0, 0));

    // Asynchronous reset while an output is being held.
    out_ready = 1'b0;
    drive(mk(49, 3, 4, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("rst_mid.held", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 0);
    check("rst_mid.out_pc", 32'(out_pc), 0);
    check("rst_mid.out_prs1", 32'(out_prs1), 0);
    check("rst_mid.out_prs2", 32'(out_prs2), 0);
    check("rst_mid.out_rob_tag", 32'(out_rob_tag), 0);
    check("rst_mid.in_ready", 32'(in_ready), 1);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    apply("rst_x1", mk(50, 0, 0, 1, 1, 0, 0, 32, 1, 0));
    apply("rst_x2", mk(51, 1, 1, 2, 1, 32, 32, 33, 2, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
